cmd_input: RTL and testbench

Input front end for the calculator: takes the raw board buttons and switches, synchronises and debounces them, and turns each button press into one command. Each command carries the button index and a snapshot of the switches. Commands are queued in a small FIFO and delivered to the calculator core over a valid/ready handshake. This replaces the bare two-flop synchronisers in the top level; it is the input-side counterpart of the display driver.

---
 rtl/calc_pkg.sv | 21 ++
 rtl/btn_debounce.sv | 99 +++++++++
 rtl/cmd_input.sv | 112 +++++++++++
 tb/tb_cmd_input.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/calc_pkg.sv
// calc_pkg: types and constants shared by the calculator input path.
package calc_pkg;

  localparam int NUM_BTN = 4;

  typedef struct packed {
    logic [1:0] btn;
    logic [7:0] sw;
  } cmd_t;

  // Index of the lowest set bit of v; 0 when no bit is set.
  function automatic logic [1:0] lowest_set(input logic [NUM_BTN-1:0] v);
    logic [1:0] idx;
    idx = '0;
    for (int unsigned i = NUM_BTN; i > 0; i--) begin
      if (v[i-1]) idx = 2'(i - 1);
    end
    return idx;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// btn_debounce: 2-flop synchroniser, debounce counter and stable bit for one button.
// press_o is a one-cycle registered pulse on each accepted 0->1 transition.
// With CMD_INPUT_REPEAT_EN defined, a hold counter also pulses press_o while held.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int REPEAT_DELAY    = 20,
  parameter int REPEAT_PERIOD   = 8
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic btn_i,
  output logic level_o,
  output logic press_o
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CntLast = CW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]    sync_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          stable_q, stable_d;
  logic          press_q, press_d;
  logic          rep_fire;

  // Debounce: count consecutive cycles the synchronised level differs from the stable bit.
  always_comb begin
    cnt_d    = cnt_q;
    stable_d = stable_q;
    if (sync_q[1] == stable_q) begin
      cnt_d = '0;
    end else if (cnt_q == CntLast) begin
      stable_d = ~stable_q;
      cnt_d    = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
    press_d = (stable_d & ~stable_q) | rep_fire;
  end

  // Synchroniser, debounce state and registered press pulse.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q   <= '0;
      cnt_q    <= '0;
      stable_q <= 1'b0;
      press_q  <= 1'b0;
    end else begin
      sync_q   <= {sync_q[0], btn_i};
      cnt_q    <= cnt_d;
      stable_q <= stable_d;
      press_q  <= press_d;
    end
  end

`ifdef CMD_INPUT_REPEAT_EN
  localparam int HMax = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int HW   = $clog2(HMax + 1);

  logic [HW-1:0] hold_q, hold_d;
  logic          rep_q, rep_d;

  // Hold timer: first fire after REPEAT_DELAY held cycles, then every REPEAT_PERIOD.
  always_comb begin
    hold_d   = hold_q;
    rep_d    = rep_q;
    rep_fire = 1'b0;
    if (!stable_q) begin
      hold_d = '0;
      rep_d  = 1'b0;
    end else if (hold_q == (rep_q ? HW'(REPEAT_PERIOD - 1) : HW'(REPEAT_DELAY - 1))) begin
      rep_fire = 1'b1;
      hold_d   = '0;
      rep_d    = 1'b1;
    end else begin
      hold_d = hold_q + 1'b1;
    end
  end

  // Hold timer registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      hold_q <= '0;
      rep_q  <= 1'b0;
    end else begin
      hold_q <= hold_d;
      rep_q  <= rep_d;
    end
  end
`else
  // Repeat timing is not built; the parameters stay in the interface only.
  if (REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_repeat_unused
  end
  assign rep_fire = 1'b0;
`endif

  assign level_o = stable_q;
  assign press_o = press_q;

endmodule

// File: rtl/cmd_input.sv
// cmd_input: synchronises and debounces board buttons/switches and queues one
// {button, switch snapshot} command per press in a show-ahead FIFO.
// CMD_INPUT_REPEAT_EN enables hold-to-repeat presses in btn_debounce.
module cmd_input
  import calc_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int FIFO_DEPTH      = 4,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 5000000
) (
  input  logic       mclk,
  input  logic       rst,
  input  logic [7:0] sw,
  input  logic [3:0] btn,
  output logic       cmd_valid,
  input  logic       cmd_ready,
  output logic [1:0] cmd_btn,
  output logic [7:0] cmd_sw,
  output logic [3:0] btn_level,
  output logic       overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);

  logic [7:0]         sw_meta_q, sw_sync_q;
  logic [NUM_BTN-1:0] press;
  logic [NUM_BTN-1:0] pend_q, pend_d;
  logic [7:0]         snap_q [NUM_BTN];
  logic [7:0]         snap_d [NUM_BTN];
  logic               ovf_q, ovf_d;
  cmd_t               mem_q [FIFO_DEPTH];
  logic [AW-1:0]      wr_q, rd_q;
  logic [AW:0]        cnt_q, cnt_d;
  logic               full, pop, push;
  logic [1:0]         grant;
  cmd_t               wr_entry, head;

  for (genvar g = 0; g < NUM_BTN; g++) begin : g_btn
    btn_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .REPEAT_DELAY   (REPEAT_DELAY),
      .REPEAT_PERIOD  (REPEAT_PERIOD)
    ) u_db (
      .clk_i  (mclk),
      .rst_i  (rst),
      .btn_i  (btn[g]),
      .level_o(btn_level[g]),
      .press_o(press[g])
    );
  end

  // Arbiter and pending/overflow bookkeeping; a pop frees a slot for a same-cycle push.
  always_comb begin
    full           = (cnt_q == (AW + 1)'(FIFO_DEPTH));
    pop            = cmd_valid & cmd_ready;
    grant          = lowest_set(pend_q);
    push           = (|pend_q) & (~full | pop);
    wr_entry.btn   = grant;
    wr_entry.sw    = snap_q[grant];
    pend_d         = pend_q;
    snap_d         = snap_q;
    ovf_d          = ovf_q;
    if (push) pend_d[grant] = 1'b0;
    for (int unsigned i = 0; i < NUM_BTN; i++) begin
      if (press[i]) begin
        if (pend_q[i]) begin
          ovf_d = 1'b1;
        end else begin
          pend_d[i] = 1'b1;
          snap_d[i] = sw_sync_q;
        end
      end
    end
    cnt_d = cnt_q + (AW + 1)'(push) - (AW + 1)'(pop);
  end

  // Switch synchroniser, pending state, snapshots and FIFO pointers.
  always_ff @(posedge mclk) begin
    if (rst) begin
      sw_meta_q <= '0;
      sw_sync_q <= '0;
      pend_q    <= '0;
      snap_q    <= '{default: '0};
      ovf_q     <= 1'b0;
      wr_q      <= '0;
      rd_q      <= '0;
      cnt_q     <= '0;
    end else begin
      sw_meta_q <= sw;
      sw_sync_q <= sw_meta_q;
      pend_q    <= pend_d;
      snap_q    <= snap_d;
      ovf_q     <= ovf_d;
      cnt_q     <= cnt_d;
      if (push) wr_q <= wr_q + 1'b1;
      if (pop)  rd_q <= rd_q + 1'b1;
    end
  end

  // Command storage; contents are only observed through the valid-gated head.
  always_ff @(posedge mclk) begin
    if (!rst && push) mem_q[wr_q] <= wr_entry;
  end

  assign head      = mem_q[rd_q];
  assign cmd_valid = (cnt_q != '0);
  assign cmd_btn   = cmd_valid ? head.btn : '0;
  assign cmd_sw    = cmd_valid ? head.sw  : '0;
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_cmd_input.sv
// tb_cmd_input: directed steps plus randomized button/ready traffic for cmd_input,
// checked every cycle against a queue-based reference model.
module tb_cmd_input;
  import calc_pkg::*;

  localparam int D = 4, DEPTH = 4, RD = 20, RP = 8;

  logic       mclk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] sw = '0;
  logic [3:0] btn = '0;
  logic       cmd_ready = 1'b0;
  logic       cmd_valid;
  logic [1:0] cmd_btn;
  logic [7:0] cmd_sw;
  logic [3:0] btn_level;
  logic       overflow;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 mclk = ~mclk;

  cmd_input #(
    .DEBOUNCE_CYCLES(D),
    .FIFO_DEPTH     (DEPTH),
    .REPEAT_DELAY   (RD),
    .REPEAT_PERIOD  (RP)
  ) dut (
    .mclk     (mclk),
    .rst      (rst),
    .sw       (sw),
    .btn      (btn),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_btn  (cmd_btn),
    .cmd_sw   (cmd_sw),
    .btn_level(btn_level),
    .overflow (overflow)
  );

  // Reference model state
  cmd_t       mq[$];
  logic [3:0] m_s1 = '0, m_s2 = '0, m_lvl = '0, m_press = '0, m_pend = '0;
  logic [7:0] m_sw1 = '0, m_sw2 = '0;
  logic [7:0] m_snap [4];
  int         m_run [4];
  int         m_age [4];
  logic       m_ovf = 1'b0;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance the model by one clock edge using the inputs the DUT is about to sample.
  task automatic model_step();
    logic [3:0] old_pend, nlvl, npress;
    int qn;
    bit popped, granted;
    cmd_t e;
    if (rst) begin
      mq.delete();
      m_s1 = '0; m_s2 = '0; m_lvl = '0; m_press = '0; m_pend = '0;
      m_sw1 = '0; m_sw2 = '0; m_ovf = 1'b0;
      for (int i = 0; i < 4; i++) begin
        m_snap[i] = '0; m_run[i] = 0; m_age[i] = 0;
      end
    end else begin
      old_pend = m_pend;
      qn = mq.size();
      popped = (qn > 0) && cmd_ready;
      if (popped) void'(mq.pop_front());
      granted = 1'b0;
      if (qn < DEPTH || popped) begin
        for (int i = 0; i < 4; i++) begin
          if (old_pend[i] && !granted) begin
            e.btn = 2'(i);
            e.sw  = m_snap[i];
            mq.push_back(e);
            m_pend[i] = 1'b0;
            granted = 1'b1;
          end
        end
      end
      for (int i = 0; i < 4; i++) begin
        if (m_press[i]) begin
          if (old_pend[i]) m_ovf = 1'b1;
          else begin
            m_pend[i] = 1'b1;
            m_snap[i] = m_sw2;
          end
        end
      end
      for (int i = 0; i < 4; i++) begin
        nlvl[i] = m_lvl[i];
        npress[i] = 1'b0;
        if (m_s2[i] != m_lvl[i]) begin
          m_run[i]++;
          if (m_run[i] == D) begin
            nlvl[i] = ~m_lvl[i];
            m_run[i] = 0;
            npress[i] = nlvl[i];
          end
        end else begin
          m_run[i] = 0;
        end
`ifdef CMD_INPUT_REPEAT_EN
        if (m_lvl[i]) begin
          m_age[i]++;
          if (m_age[i] == RD || (m_age[i] > RD && (m_age[i] - RD) % RP == 0)) npress[i] = 1'b1;
        end else begin
          m_age[i] = 0;
        end
`endif
      end
      m_lvl = nlvl;
      m_press = npress;
      m_s2 = m_s1;
      m_s1 = btn;
      m_sw2 = m_sw1;
      m_sw1 = sw;
    end
  endtask

  task automatic check_model();
    cmd_t h;
    logic v;
    v = (mq.size() > 0);
    h = '0;
    if (v) h = mq[0];
    chk("model_valid", 32'(cmd_valid), 32'(v));
    chk("model_btn", 32'(cmd_btn), 32'(h.btn));
    chk("model_sw", 32'(cmd_sw), 32'(h.sw));
    chk("model_level", 32'(btn_level), 32'(m_lvl));
    chk("model_overflow", 32'(overflow), 32'(m_ovf));
  endtask

  // One clock: model predicts, DUT samples, outputs checked on the falling edge.
  task automatic tick();
    model_step();
    @(posedge mclk);
    @(negedge mclk);
    check_model();
  endtask

  int   flips;
  logic prev_lvl;

  task automatic tick_flip1();
    tick();
    if (btn_level[1] !== prev_lvl) begin
      flips++;
      prev_lvl = btn_level[1];
    end
  endtask

  task automatic press_btn(int b, int hold, logic [7:0] swv);
    sw = swv;
    btn[b] = 1'b1;
    repeat (hold) tick();
    btn[b] = 1'b0;
    repeat (8) tick();
  endtask

  initial begin
    int   got_b[$];
    int   got_s[$];
    int   got_t[$];
    int   exp_b[6];
    int   exp_s[6];
    int   exp_t[6];
    int   rem[4];
    int   rmode;

    // Reset state
    repeat (3) tick();
    chk("rst_valid", 32'(cmd_valid), 32'd0);
    chk("rst_btn", 32'(cmd_btn), 32'd0);
    chk("rst_sw", 32'(cmd_sw), 32'd0);
    chk("rst_level", 32'(btn_level), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    rst = 1'b0;
    repeat (3) tick();

    // Clean press of btn[2] with back-pressure
    sw = 8'h5A; btn[2] = 1'b1; cmd_ready = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      tick();
      if (k == 5) chk("clean_level_pre", 32'(btn_level), 32'h0);
      if (k == 6) chk("clean_level_flip", 32'(btn_level), 32'h4);
      if (k == 7) chk("clean_valid_pre", 32'(cmd_valid), 32'd0);
    end
    chk("clean_valid", 32'(cmd_valid), 32'd1);
    chk("clean_btn", 32'(cmd_btn), 32'd2);
    chk("clean_sw", 32'(cmd_sw), 32'h5A);
    sw = 8'h00;
    repeat (5) tick();
    chk("clean_hold_valid", 32'(cmd_valid), 32'd1);
    chk("clean_hold_btn", 32'(cmd_btn), 32'd2);
    chk("clean_hold_sw", 32'(cmd_sw), 32'h5A);
    cmd_ready = 1'b1;
    tick();
    chk("clean_popped", 32'(cmd_valid), 32'd0);
    cmd_ready = 1'b0; btn[2] = 1'b0;
    repeat (10) tick();

    // Bounce on btn[1]: 3-cycle pulses, then held
    flips = 0; prev_lvl = btn_level[1]; sw = 8'h21;
    repeat (3) begin
      btn[1] = 1'b1; repeat (3) tick_flip1();
      btn[1] = 1'b0; repeat (3) tick_flip1();
    end
    btn[1] = 1'b1;
    repeat (12) tick_flip1();
    chk("bounce_flips", 32'(flips), 32'd1);
    chk("bounce_valid", 32'(cmd_valid), 32'd1);
    chk("bounce_btn", 32'(cmd_btn), 32'd1);
    cmd_ready = 1'b1;
    tick();
    chk("bounce_single", 32'(cmd_valid), 32'd0);
    cmd_ready = 1'b0; btn[1] = 1'b0;
    repeat (10) tick();

    // Simultaneous presses of btn[3] and btn[0]
    sw = 8'h33; cmd_ready = 1'b1; btn = 4'b1001;
    repeat (7) tick();
    chk("sim_valid_pre", 32'(cmd_valid), 32'd0);
    tick();
    chk("sim_first_valid", 32'(cmd_valid), 32'd1);
    chk("sim_first_btn", 32'(cmd_btn), 32'd0);
    chk("sim_first_sw", 32'(cmd_sw), 32'h33);
    tick();
    chk("sim_second_valid", 32'(cmd_valid), 32'd1);
    chk("sim_second_btn", 32'(cmd_btn), 32'd3);
    tick();
    chk("sim_drained", 32'(cmd_valid), 32'd0);
    btn = 4'b0000; cmd_ready = 1'b0;
    repeat (10) tick();

    // Back-pressure: fill FIFO, two waiting presses, then a dropped re-press
    for (int i = 0; i < 6; i++) press_btn(i % 4, 9, 8'(8'h10 + i));
    chk("bp_overflow_clear", 32'(overflow), 32'd0);
    chk("bp_head_valid", 32'(cmd_valid), 32'd1);
    chk("bp_head_btn", 32'(cmd_btn), 32'd0);
    press_btn(0, 9, 8'h16);
    chk("bp_overflow_set", 32'(overflow), 32'd1);
    cmd_ready = 1'b1;
    for (int k = 0; k < 12; k++) begin
      if (cmd_valid) begin
        got_b.push_back(int'(cmd_btn));
        got_s.push_back(int'(cmd_sw));
      end
      tick();
    end
    cmd_ready = 1'b0;
    exp_b = '{0, 1, 2, 3, 0, 1};
    exp_s = '{'h10, 'h11, 'h12, 'h13, 'h14, 'h15};
    chk("bp_drain_count", 32'(got_b.size()), 32'd6);
    for (int i = 0; i < got_b.size() && i < 6; i++) begin
      chk("bp_drain_btn", 32'(got_b[i]), 32'(exp_b[i]));
      chk("bp_drain_sw", 32'(got_s[i]), 32'(exp_s[i]));
    end
    chk("bp_overflow_sticky", 32'(overflow), 32'd1);

    // Reset in the middle of a debounce with btn[3] held
    sw = 8'h77; btn[3] = 1'b1;
    repeat (4) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rstmid_overflow", 32'(overflow), 32'd0);
    for (int k = 1; k <= 7; k++) begin
      tick();
      chk("rstmid_quiet", 32'(cmd_valid), 32'd0);
    end
    tick();
    chk("rstmid_valid", 32'(cmd_valid), 32'd1);
    chk("rstmid_btn", 32'(cmd_btn), 32'd3);
    cmd_ready = 1'b1;
    tick();
    chk("rstmid_single", 32'(cmd_valid), 32'd0);
    cmd_ready = 1'b0; btn[3] = 1'b0;
    repeat (10) tick();

`ifdef CMD_INPUT_REPEAT_EN
    // Auto-repeat while btn[0] is held
    cmd_ready = 1'b1; sw = 8'hC3; btn[0] = 1'b1;
    for (int k = 1; k <= 80; k++) begin
      if (k == 59) btn[0] = 1'b0;
      tick();
      if (cmd_valid) got_t.push_back(k);
    end
    exp_t = '{8, 28, 36, 44, 52, 60};
    chk("repeat_count", 32'(got_t.size()), 32'd6);
    for (int i = 0; i < got_t.size() && i < 6; i++)
      chk("repeat_time", 32'(got_t[i]), 32'(exp_t[i]));
    cmd_ready = 1'b0;
    repeat (10) tick();
`endif

    // Randomized traffic against the reference model
    for (int i = 0; i < 4; i++) rem[i] = int'($urandom_range(1, 14));
    rmode = 0;
    for (int t = 0; t < 1500; t++) begin
      for (int i = 0; i < 4; i++) begin
        rem[i]--;
        if (rem[i] == 0) begin
          btn[i] = ~btn[i];
          rem[i] = int'($urandom_range(1, 14));
        end
      end
      if (t % 64 == 0) rmode = int'($urandom_range(0, 2));
      cmd_ready = (rmode == 2) ? 1'b1 : (rmode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
      if ($urandom_range(0, 9) == 0) sw = 8'($urandom);
      rst = ($urandom_range(0, 499) == 0);
      tick();
    end
    rst = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
